// File: rtl/mem_copy_if.sv
// mem_copy_if: request/status handshake plus data-memory port of the copy engine
interface mem_copy_if #(parameter int LW = 6);
  logic          start;
  logic [31:0]   src;
  logic [31:0]   dst;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic          err;
  logic          mem_we;
  logic [31:0]   mem_wd;
  logic [31:0]   mem_a;
  logic [31:0]   mem_rd;
  modport master (output start, src, dst, len, mem_rd, input busy, done, err, mem_we, mem_wd, mem_a);
  modport slave  (input start, src, dst, len, mem_rd, output busy, done, err, mem_we, mem_wd, mem_a);
endinterface

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: copies len words src->dst, one read cycle then one write cycle per word
module mem_copy_engine #(
  parameter int DEPTH = 32,
  parameter int LW    = 6
) (
  input  logic clk,
  input  logic rst_n,
  mem_copy_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t        state_q, state_d;
  logic [31:0]   src_q, src_d, dst_q, dst_d, buf_q, buf_d;
  logic [LW-1:0] len_q, len_d, i_q, i_d;
  logic          err_q, err_d;
  logic          bad;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      buf_q   <= '0;
      len_q   <= '0;
      i_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      buf_q   <= buf_d;
      len_q   <= len_d;
      i_q     <= i_d;
      err_q   <= err_d;
    end
  // Range sums are 33 bits wide so a huge src/dst cannot wrap into range
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    buf_d   = buf_q;
    len_d   = len_q;
    i_d     = i_q;
    err_d   = err_q;
    bad     = ({1'b0, bus.src} + 33'(bus.len) > 33'(DEPTH)) ||
              ({1'b0, bus.dst} + 33'(bus.len) > 33'(DEPTH));
    case (state_q)
      IDLE: if (bus.start) begin
        src_d   = bus.src;
        dst_d   = bus.dst;
        len_d   = bus.len;
        i_d     = '0;
        err_d   = (bus.len != '0) && bad;
        state_d = (bus.len == '0 || bad) ? DONE : READ;
      end
      READ: begin
        buf_d   = bus.mem_rd;
        state_d = WRITE;
      end
      WRITE: begin
        i_d     = i_q + LW'(1);
        state_d = (i_q + LW'(1) == len_q) ? DONE : READ;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.busy   = (state_q == READ) || (state_q == WRITE);
  assign bus.done   = state_q == DONE;
  assign bus.err    = err_q;
  assign bus.mem_we = state_q == WRITE;
  assign bus.mem_wd = (state_q == WRITE) ? buf_q : '0;
  assign bus.mem_a  = (state_q == READ)  ? src_q + 32'(i_q) :
                      (state_q == WRITE) ? dst_q + 32'(i_q) : '0;
endmodule
